seq_restoring_divider: RTL and testbench
========================================

// Module: seq_restoring_divider
// PURPOSE
//  Parametrised multi-cycle restoring divider: latches dividend/divisor on a valid/ready
//  handshake, iterates one quotient bit per clock, and returns quotient/remainder with a
//  valid/ready output handshake. Successor of the fixed 32-bit divisor register and
//  datapath: adds width/sign generics, divide-by-zero/overflow flags, mid-op reset abort.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=2)
//  SIGNED  0   0: unsigned divide; 1: two's-complement divide, truncate toward zero
// PORTS
//  Clk          in   1      clock, all state updates on rising edge
//  Reset        in   1      reset, synchronous, active-high
//  in_valid     in   1      dividend/divisor valid
//  in_ready     out  1      block can accept operands
//  dividend     in   WIDTH  numerator
//  divisor      in   WIDTH  denominator
//  out_valid    out  1      results valid, held until consumed
//  out_ready    in   1      consumer takes results
//  quotient     out  WIDTH  quotient
//  remainder    out  WIDTH  remainder
//  div_by_zero  out  1      divisor was 0 for this result
//  overflow     out  1      SIGNED=1 only: MIN / -1
// BEHAVIOUR
//  - Reset (sampled on edge): state->IDLE; quotient, remainder, flags, out_valid, count = 0.
//    Reset mid-RUN or mid-DONE aborts; pending result discarded, never presented.
//  - in_ready = (state==IDLE) && !Reset. Accept = in_valid && in_ready.
//  - States: IDLE -accept, divisor!=0-> RUN; IDLE -accept, divisor==0-> DONE;
//    RUN -count==WIDTH-1-> DONE; DONE -out_ready-> IDLE. No other transitions.
//  - Latency: operands accepted at edge N -> out_valid high after edge N+WIDTH+1.
//    Divide-by-zero: out_valid high after edge N+1.
//  - RUN: {rem,quo} shifted left 1; trial = rem_shifted - |divisor| (WIDTH+1 bits);
//    trial>=0 -> rem=trial, quo LSB=1; else restore, LSB=0. count 0..WIDTH-1.
//  - SIGNED=1: operate on magnitudes; quotient negated if signs differ, remainder takes
//    dividend's sign. MIN/-1: quotient=MIN (wrap), remainder=0, overflow=1.
//  - Divide-by-zero: quotient = all ones, remainder = dividend, div_by_zero=1, overflow=0.
//  - out_valid and all result outputs stable through DONE until out_ready sampled high;
//    outputs keep last value after hand-off (not cleared) until next result or Reset.
//  - In DONE with out_ready && in_valid same cycle: result consumed, operands NOT accepted
//    (in_ready=0); earliest next accept is the following cycle in IDLE.
//  - in_valid ignored outside IDLE; operand inputs sampled only at accept.
// STRUCTURE
//  - div_pkg: state enum {IDLE,RUN,DONE}, localparam CNT_W = $clog2(WIDTH).
//  - Sub-module div_step: combinational single restoring iteration
//    (rem_in, quo_in, dvsr -> rem_out, quo_out); instantiated once in RUN path.
//  - Top holds FSM, counter, operand/sign registers, sign fix-up and output registers.
// TESTING
//  1. WIDTH=32 unsigned: 100/7 -> after 33 edges out_valid, q=14, r=2, flags 0.
//  2. Divisor 0, dividend 0x1234 -> next cycle out_valid, q=0xFFFFFFFF, r=0x1234,
//     div_by_zero=1.
//  3. SIGNED=1: -7/2 -> q=-3, r=-1; 7/-2 -> q=-3, r=1;
//     0x80000000/-1 -> q=0x80000000, r=0, overflow=1.
//  4. Reset asserted at count 10 of 100/7 -> next cycle in_ready=1, out_valid never rises,
//     outputs 0.
//  5. Backpressure: hold out_ready=0 for 20 cycles after done -> results stable, in_ready=0;
//     raise out_ready with in_valid high -> accept only on following cycle.
//  6. WIDTH=8 unsigned: 255/1 -> q=255, r=0 after 9 edges; 3/200 -> q=0, r=3.

Source files
------------

// File: rtl/seq_restoring_divider_pkg.sv
// Shared types for the sequential restoring divider: FSM state encoding and
// a helper that sizes the iteration counter for a given operand width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_DEFAULT_WIDTH = 32;

  // Counter must hold 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, try to
// subtract the divisor magnitude, keep the difference if it did not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           fits;

  // Trial subtraction; the partial remainder stays below the divisor, so the
  // kept value always fits back into WIDTH bits.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvsr});
    trial   = shifted - {1'b0, dvsr};
    rem_out = fits ? WIDTH'(trial) : WIDTH'(shifted);
    quo_out = {quo_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider with valid/ready handshakes on both sides.
// One quotient bit per clock on operand magnitudes, then a single DONE cycle
// applies sign fix-up into the output registers before out_valid rises.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH  = DIV_DEFAULT_WIDTH,
  parameter bit SIGNED = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int              CNT_W   = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_out_q, dbz_out_d;
  logic             ovf_out_q, ovf_out_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             divisor_zero, min_by_neg_one;
  logic [WIDTH-1:0] step_rem, step_quo;

  assign in_ready    = (state_q == IDLE) && !Reset;
  assign accept      = in_valid && in_ready;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_out_q;
  assign overflow    = ovf_out_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .dvsr    (dvsr_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Operand conditioning: signs, magnitudes and the two special cases.
  always_comb begin
    dvd_neg        = SIGNED && dividend[WIDTH-1];
    dvs_neg        = SIGNED && divisor[WIDTH-1];
    dvd_mag        = dvd_neg ? -dividend : dividend;
    dvs_mag        = dvs_neg ? -divisor : divisor;
    divisor_zero   = (divisor == '0);
    min_by_neg_one = SIGNED && (dividend == MIN_VAL) && (divisor == '1);
  end

  // FSM next state plus datapath/output register next values.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    dvd_raw_d   = dvd_raw_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_out_d   = dbz_out_q;
    ovf_out_d   = ovf_out_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          dvd_raw_d = dividend;
          dvsr_d    = dvs_mag;
          quo_d     = dvd_mag;
          rem_d     = '0;
          count_d   = '0;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          dbz_d     = divisor_zero;
          ovf_d     = min_by_neg_one;
          state_d   = divisor_zero ? DONE : RUN;
        end
      end

      RUN: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          count_d = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        // First DONE cycle builds the result; later cycles wait for the consumer.
        if (!out_valid_q) begin
          if (dbz_q) begin
            quotient_d  = '1;
            remainder_d = dvd_raw_q;
          end else if (ovf_q) begin
            quotient_d  = MIN_VAL;
            remainder_d = '0;
          end else begin
            quotient_d  = neg_quo_q ? -quo_q : quo_q;
            remainder_d = neg_rem_q ? -rem_q : rem_q;
          end
          dbz_out_d   = dbz_q;
          ovf_out_d   = ovf_q;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight result.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      dvd_raw_q   <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_out_q   <= 1'b0;
      ovf_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      dvd_raw_q   <= dvd_raw_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_out_q   <= dbz_out_d;
      ovf_out_q   <= ovf_out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: three instances (32-bit unsigned, 32-bit
// signed, 8-bit unsigned) driven from a vector table, a random unsigned loop
// and hand-written abort/backpressure sequences, checked via a scoreboard queue.
`timescale 1ns/1ps
module tb_seq_restoring_divider;

  typedef struct {
    int unsigned sel;   // 0: u32, 1: s32, 2: u8
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
  } vec_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic [31:0] dividend, divisor;
  logic        out_ready;
  logic        iv_u, iv_s, iv_8;
  logic        ir_u, ir_s, ir_8;
  logic        ov_u, ov_s, ov_8;
  logic [31:0] q_u, r_u, q_s, r_s;
  logic [7:0]  q_8, r_8;
  logic        dz_u, dz_s, dz_8, of_u, of_s, of_8;

  seq_restoring_divider #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
    .Clk(Clk), .Reset(Reset), .in_valid(iv_u), .in_ready(ir_u),
    .dividend(dividend), .divisor(divisor), .out_valid(ov_u), .out_ready(out_ready),
    .quotient(q_u), .remainder(r_u), .div_by_zero(dz_u), .overflow(of_u));

  seq_restoring_divider #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
    .Clk(Clk), .Reset(Reset), .in_valid(iv_s), .in_ready(ir_s),
    .dividend(dividend), .divisor(divisor), .out_valid(ov_s), .out_ready(out_ready),
    .quotient(q_s), .remainder(r_s), .div_by_zero(dz_s), .overflow(of_s));

  seq_restoring_divider #(.WIDTH(8), .SIGNED(1'b0)) dut_8 (
    .Clk(Clk), .Reset(Reset), .in_valid(iv_8), .in_ready(ir_8),
    .dividend(dividend[7:0]), .divisor(divisor[7:0]), .out_valid(ov_8), .out_ready(out_ready),
    .quotient(q_8), .remainder(r_8), .div_by_zero(dz_8), .overflow(of_8));

  int unsigned sel;
  logic        cur_valid, cur_ready, cur_dbz, cur_ovf;
  logic [31:0] cur_q, cur_r;

  // View of the instance currently under test.
  always_comb begin
    cur_valid = ov_u; cur_ready = ir_u; cur_q = q_u; cur_r = r_u; cur_dbz = dz_u; cur_ovf = of_u;
    if (sel == 1) begin
      cur_valid = ov_s; cur_ready = ir_s; cur_q = q_s; cur_r = r_s; cur_dbz = dz_s; cur_ovf = of_s;
    end else if (sel == 2) begin
      cur_valid = ov_8; cur_ready = ir_8; cur_q = {24'h0, q_8}; cur_r = {24'h0, r_8};
      cur_dbz = dz_8; cur_ovf = of_8;
    end
  end

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    iv_u = (sel == 0) && v;
    iv_s = (sel == 1) && v;
    iv_8 = (sel == 2) && v;
  endtask

  function automatic vec_t mk(input int unsigned s, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] q, input logic [31:0] r,
                              input logic dbz, input logic ovf);
    vec_t v;
    v.sel = s; v.a = a; v.b = b; v.q = q; v.r = r; v.dbz = dbz; v.ovf = ovf;
    return v;
  endfunction

  function automatic int lat_of(input vec_t v);
    if (v.dbz) return 1;
    return (v.sel == 2) ? 9 : 33;
  endfunction

  // Present operands for one cycle; called #1 after an edge with the DUT idle.
  task automatic send(input vec_t v);
    sel = v.sel; dividend = v.a; divisor = v.b;
    set_valid(1'b1);
    #1;
    check("in_ready_before_accept", {31'd0, cur_ready}, 32'd1);
    @(posedge Clk); #1;
    set_valid(1'b0);
    exp_q.push_back(v);
  endtask

  // Wait (bounded) for out_valid, measure edges since accept.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!cur_valid && edges < 100) begin
      @(posedge Clk); #1;
      edges++;
    end
  endtask

  // Compare the presented result with the scoreboard head, then hand it off.
  task automatic collect(input int lat);
    vec_t e;
    int   edges;
    wait_valid(edges);
    check("latency", edges, lat);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: result with empty queue, got 0x%08h expected none", cur_q);
      return;
    end
    e = exp_q.pop_front();
    check("quotient", cur_q, e.q);
    check("remainder", cur_r, e.r);
    check("div_by_zero", {31'd0, cur_dbz}, {31'd0, e.dbz});
    check("overflow", {31'd0, cur_ovf}, {31'd0, e.ovf});
    $display("txn inst=%0d a=0x%08h b=0x%08h -> q=0x%08h r=0x%08h dbz=%0b ovf=%0b lat=%0d",
             e.sel, e.a, e.b, cur_q, cur_r, cur_dbz, cur_ovf, edges);
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_handoff", {31'd0, cur_valid}, 32'd0);
    check("in_ready_after_handoff", {31'd0, cur_ready}, 32'd1);
    check("quotient_held_after_handoff", cur_q, e.q);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   edges;
    logic seen;

    vecs[0]  = mk(0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0);
    vecs[1]  = mk(0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1, 1'b0);
    vecs[2]  = mk(0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0);
    vecs[3]  = mk(0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0, 1'b0);
    vecs[4]  = mk(0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1'b0);
    vecs[5]  = mk(1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0);
    vecs[6]  = mk(1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0);
    vecs[7]  = mk(1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1);
    vecs[8]  = mk(1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 1'b0);
    vecs[9]  = mk(1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, 1'b0);
    vecs[10] = mk(1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1, 1'b0);
    vecs[11] = mk(2, 32'd255,        32'd1,          32'd255,        32'd0,          1'b0, 1'b0);
    vecs[12] = mk(2, 32'd3,          32'd200,        32'd0,          32'd3,          1'b0, 1'b0);
    vecs[13] = mk(2, 32'd200,        32'd0,          32'h0000_00FF,  32'h0000_00C8,  1'b1, 1'b0);

    sel = 0; dividend = '0; divisor = '0; out_ready = 1'b0;
    iv_u = 1'b0; iv_s = 1'b0; iv_8 = 1'b0;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_in_ready_low", {29'd0, ir_u, ir_s, ir_8}, 32'd0);
    check("reset_out_valid_low", {29'd0, ov_u, ov_s, ov_8}, 32'd0);
    check("reset_quotient_zero", q_u | q_s | {24'd0, q_8}, 32'd0);
    check("reset_remainder_zero", r_u | r_s | {24'd0, r_8}, 32'd0);
    check("reset_flags_zero", {26'd0, dz_u, dz_s, dz_8, of_u, of_s, of_8}, 32'd0);
    Reset = 1'b0;
    #1;
    check("in_ready_after_reset", {29'd0, ir_u, ir_s, ir_8}, 32'd7);

    // Table-driven vectors.
    for (int i = 0; i < 14; i++) begin
      send(vecs[i]);
      collect(lat_of(vecs[i]));
    end

    // Random unsigned 32-bit vectors against the bench's own arithmetic.
    for (int i = 0; i < 6; i++) begin
      v.sel = 0; v.a = $urandom; v.b = $urandom_range(1, 50000);
      v.q = v.a / v.b; v.r = v.a % v.b; v.dbz = 1'b0; v.ovf = 1'b0;
      send(v);
      collect(33);
    end

    // Abort: reset at count 10 of 100/7; outputs must end at zero, never valid.
    send(vecs[0]);
    collect(33);
    send(vecs[0]);
    repeat (10) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    check("abort_in_ready_during_reset", {31'd0, cur_ready}, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    #1;
    exp_q.delete();
    check("abort_in_ready", {31'd0, cur_ready}, 32'd1);
    check("abort_out_valid", {31'd0, cur_valid}, 32'd0);
    check("abort_quotient", cur_q, 32'd0);
    check("abort_remainder", cur_r, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (cur_valid) seen = 1'b1;
    end
    check("abort_out_valid_never", {31'd0, seen}, 32'd0);
    $display("txn inst=0 abort of 100/7 at count 10: out_valid seen=%0b", seen);

    // Backpressure: hold result 20 cycles, then consume with in_valid high.
    v = mk(0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0);
    send(v);
    wait_valid(edges);
    check("bp_latency", edges, 33);
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk); #1;
      check("bp_out_valid_held", {31'd0, cur_valid}, 32'd1);
      check("bp_quotient_stable", cur_q, 32'd333);
      check("bp_remainder_stable", cur_r, 32'd1);
      check("bp_in_ready_low", {31'd0, cur_ready}, 32'd0);
    end
    void'(exp_q.pop_front());
    dividend = 32'd50; divisor = 32'd5;
    set_valid(1'b1);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_low_while_consuming", {31'd0, cur_ready}, 32'd0);
    @(posedge Clk); #1;
    out_ready = 1'b0;
    check("bp_consumed", {31'd0, cur_valid}, 32'd0);
    check("bp_not_accepted", {31'd0, cur_ready}, 32'd1);
    @(posedge Clk); #1;
    set_valid(1'b0);
    check("bp_accepted_next_cycle", {31'd0, cur_ready}, 32'd0);
    $display("txn inst=0 a=0x000003e8 b=0x00000003 held 20 cycles, then 50/5 accepted one cycle after hand-off");
    exp_q.push_back(mk(0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0));
    collect(33);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
